// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcode constants, instruction width,
// and the fetch-queue entry layout.
package mips32_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQZ    = 6'b000100;
    localparam logic [5:0] OP_BNEQZ   = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_HLT     = 6'b111111;

    // One buffered instruction together with the address that follows it.
    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [INSTR_W-1:0] npc;
    } fetch_entry_t;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic is_hlt(input logic [INSTR_W-1:0] ir);
        return opcode_of(ir) == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Register FIFO for fetched instructions. The head is held in its own
// register, loaded from either storage or the incoming word, so the head
// outputs never depend combinationally on push and keep their last value
// once the queue runs empty.
module mips32_sync_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [INSTR_W-1:0]     push_ir,
    input  logic [INSTR_W-1:0]     push_npc,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [INSTR_W-1:0]     head_ir,
    output logic [INSTR_W-1:0]     head_npc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      head_q, head_d, in_e;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d, remain;
    logic              do_push, do_pop;

    assign in_e    = '{ir: push_ir, npc: push_npc};
    // The producer only pushes when it holds a credit, so no full check here.
    assign do_push = push & ~flush;
    assign do_pop  = pop & (count_q != '0);

    // Next pointers, occupancy and the entry that becomes head after this edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        remain   = count_q - CW'(do_pop);
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (count_d != '0) begin
            // Nothing older left behind the pop: the pushed word is the new head.
            head_d = (remain == '0) ? in_e : mem_q[rd_ptr_d];
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= in_e;
    end

    // Pointer, count and head register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count    = count_q;
    assign head_ir  = head_q.ir;
    assign head_npc = head_q.npc;

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front-end: issues one-word requests under a
// credit limit, queues responses tagged with the fetch epoch, and hands
// them to IF/ID via valid/ready. A redirect flips the epoch so every
// older response still on the way is discarded.
// Optional feature macro: FETCH_HLT_STOP_EN (stop fetching after a hlt word).
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_ir,
    output logic [31:0]        if_npc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_stopped
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  infl_addr_q;
    logic               inflight_q, infl_epoch_q, epoch_q;
    logic               stopped;
    logic [CW-1:0]      count;
    logic [UW-1:0]      used;
    logic               grant, accept, pop;
    logic [INSTR_W-1:0] rsp_npc;

    // Credit uses registered occupancy only: a pop this cycle frees nothing
    // until next cycle. Requests are held off while reset is asserted.
    assign used      = {1'b0, count} + UW'(inflight_q);
    assign imem_req  = rst_n & ~stopped & (used < UW'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;

    // A response is kept only if it belongs to the current epoch, fetching is
    // live, and no redirect is flushing the queue on this edge.
    assign accept  = imem_rvalid & inflight_q & (infl_epoch_q == epoch_q)
                   & ~stopped & ~redirect_valid;
    assign rsp_npc = INSTR_W'(infl_addr_q) + INSTR_W'(1);

    assign if_valid = (count != '0);
    assign pop      = if_valid & if_ready;

    // Next fetch address: redirect wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (grant)     pc_d = pc_q + ADDR_W'(1);
    end

    // Fetch address, epoch and the single outstanding-request tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= ADDR_W'(RESET_PC);
            epoch_q      <= 1'b0;
            inflight_q   <= 1'b0;
            infl_addr_q  <= '0;
            infl_epoch_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= grant;
            if (grant) begin
                infl_addr_q  <= pc_q;
                infl_epoch_q <= epoch_q;
            end
            if (redirect_valid) epoch_q <= ~epoch_q;
        end
    end

`ifdef FETCH_HLT_STOP_EN
    logic stopped_q;

    // Stop on a queued hlt; only a redirect restarts fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                stopped_q <= 1'b0;
        else if (redirect_valid)                   stopped_q <= 1'b0;
        else if (accept && is_hlt(imem_rdata))     stopped_q <= 1'b1;
    end

    assign stopped = stopped_q;
`else
    assign stopped = 1'b0;
`endif

    assign fetch_stopped = stopped;

    mips32_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_ir  (imem_rdata),
        .push_npc (rsp_npc),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head_ir  (if_ir),
        .head_npc (if_npc)
    );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: streaming, full, redirect, address
// wrap, hlt handling and mid-run reset. Memory returns addr+100 one cycle
// after each grant (optionally a hlt word at address 5).
module tb_mips32_fetch_queue;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt = 1'b0;
    logic              imem_rvalid = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              if_valid;
    logic              if_ready = 1'b0;
    logic [31:0]       if_ir;
    logic [31:0]       if_npc;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              fetch_stopped;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_grants = 0;
    int   g0;
    logic hlt5 = 1'b0;

    mips32_fetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_npc         (if_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_stopped  (fetch_stopped)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (hlt5 && a == ADDR_W'(5)) return 32'hFC00_0000;
        return 32'(a) + 32'd100;
    endfunction

    // Instruction memory: answers every granted request on the next edge.
    always @(posedge clk) begin
        imem_rvalid <= imem_req & imem_gnt;
        imem_rdata  <= mem_word(imem_addr);
        if (imem_req && imem_gnt) n_grants <= n_grants + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic gnt, input logic rdy);
        rst_n = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
        tick(2);
        imem_gnt = gnt; if_ready = rdy; rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick(2);
        chk("rst_req",   32'(imem_req), 0);
        chk("rst_addr",  32'(imem_addr), 0);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_ir",    if_ir, 0);
        chk("rst_npc",   if_npc, 0);
        chk("rst_stop",  32'(fetch_stopped), 0);

        // Streaming: one instruction per cycle
        imem_gnt = 1'b1; if_ready = 1'b1; rst_n = 1'b1; #1;
        chk("A_req_release", 32'(imem_req), 1);
        chk("A_addr0",       32'(imem_addr), 0);
        tick(1);
        chk("A_e1_valid", 32'(if_valid), 0);
        chk("A_e1_addr",  32'(imem_addr), 1);
        tick(1);
        chk("A_e2_valid", 32'(if_valid), 1);
        chk("A_e2_ir",    if_ir, 100);
        chk("A_e2_npc",   if_npc, 1);
        for (int k = 3; k <= 6; k++) begin
            tick(1);
            chk("A_ir",   if_ir, 32'(100 + k - 2));
            chk("A_npc",  if_npc, 32'(k - 1));
            chk("A_addr", 32'(imem_addr), 32'(k));
        end

        // Full: consumer stalled
        restart(1'b1, 1'b0);
        g0 = n_grants;
        tick(5);
        chk("B_req_full", 32'(imem_req), 0);
        chk("B_head_ir",  if_ir, 100);
        chk("B_head_npc", if_npc, 1);
        chk("B_addr",     32'(imem_addr), 4);
        tick(2);
        chk("B_grants",   32'(n_grants - g0), 4);
        chk("B_req_hold", 32'(imem_req), 0);
        if_ready = 1'b1;
        tick(1);
        chk("B_req_resume", 32'(imem_req), 1);
        chk("B_addr_resume", 32'(imem_addr), 4);
        chk("B_ir101", if_ir, 101);
        tick(1);
        chk("B_ir102", if_ir, 102);
        tick(1);
        chk("B_ir103", if_ir, 103);
        chk("B_npc103", if_npc, 4);
        tick(1);
        chk("B_ir104", if_ir, 104);
        chk("B_npc104", if_npc, 5);

        // Redirect with 3 queued and 1 in flight
        restart(1'b1, 1'b0);
        tick(4);
        chk("C_pre_req", 32'(imem_req), 0);
        chk("C_pre_ir",  if_ir, 100);
        redirect_valid = 1'b1; redirect_pc = 10'h020;
        tick(1);
        redirect_valid = 1'b0;
        chk("C_valid_flush", 32'(if_valid), 0);
        chk("C_addr_target", 32'(imem_addr), 32'h20);
        chk("C_req_target",  32'(imem_req), 1);
        tick(1);
        chk("C_valid_wait", 32'(if_valid), 0);
        tick(1);
        chk("C_valid_tgt", 32'(if_valid), 1);
        chk("C_ir_tgt",    if_ir, 32'h84);
        chk("C_npc_tgt",   if_npc, 32'h21);

        // Redirect while streaming: stale response on the following edge
        restart(1'b1, 1'b1);
        tick(4);
        chk("C2_pre_ir", if_ir, 102);
        redirect_valid = 1'b1; redirect_pc = 10'h040;
        tick(1);
        redirect_valid = 1'b0;
        chk("C2_valid_flush", 32'(if_valid), 0);
        chk("C2_addr",        32'(imem_addr), 32'h40);
        tick(1);
        chk("C2_stale_drop",  32'(if_valid), 0);
        tick(1);
        chk("C2_ir_tgt",  if_ir, 32'hA4);
        chk("C2_npc_tgt", if_npc, 32'h41);
        tick(1);
        chk("C2_ir_next", if_ir, 32'hA5);

        // Address wrap at the top of instruction memory
        redirect_valid = 1'b1; redirect_pc = 10'h3FE;
        tick(1);
        redirect_valid = 1'b0;
        chk("D_addr_3fe", 32'(imem_addr), 32'h3FE);
        tick(1);
        chk("D_addr_3ff", 32'(imem_addr), 32'h3FF);
        chk("D_valid",    32'(if_valid), 0);
        tick(1);
        chk("D_addr_wrap", 32'(imem_addr), 0);
        chk("D_ir_3fe",    if_ir, 32'h462);
        chk("D_npc_3fe",   if_npc, 32'h3FF);
        tick(1);
        chk("D_ir_3ff",  if_ir, 32'h463);
        chk("D_npc_3ff", if_npc, 32'h400);
        tick(1);
        chk("D_ir_0",  if_ir, 100);
        chk("D_npc_0", if_npc, 1);

        // hlt word at address 5
        hlt5 = 1'b1;
        restart(1'b1, 1'b1);
        tick(7);
        chk("E_ir_hlt",  if_ir, 32'hFC00_0000);
        chk("E_npc_hlt", if_npc, 6);
`ifdef FETCH_HLT_STOP_EN
        chk("E_stopped", 32'(fetch_stopped), 1);
        chk("E_req_off", 32'(imem_req), 0);
        tick(1);
        chk("E_no_after", 32'(if_valid), 0);
        tick(2);
        chk("E_still_empty", 32'(if_valid), 0);
        chk("E_still_stop",  32'(fetch_stopped), 1);
`else
        chk("E_stopped", 32'(fetch_stopped), 0);
        chk("E_req_on",  32'(imem_req), 1);
        tick(1);
        chk("E_ir6", if_ir, 106);
        tick(2);
        chk("E_ir8", if_ir, 108);
        chk("E_no_stop", 32'(fetch_stopped), 0);
`endif
        redirect_valid = 1'b1; redirect_pc = '0;
        tick(1);
        redirect_valid = 1'b0;
        chk("E_stop_clr", 32'(fetch_stopped), 0);
        chk("E_req_rst",  32'(imem_req), 1);
        chk("E_addr_0",   32'(imem_addr), 0);
        tick(2);
        chk("E_restart_valid", 32'(if_valid), 1);
        chk("E_restart_ir",    if_ir, 100);
        hlt5 = 1'b0;

        // Reset with 2 queued and 1 in flight
        restart(1'b1, 1'b0);
        tick(3);
        chk("F_pre_ir",  if_ir, 100);
        chk("F_pre_req", 32'(imem_req), 1);
        rst_n = 1'b0; #1;
        chk("F_valid", 32'(if_valid), 0);
        chk("F_req",   32'(imem_req), 0);
        chk("F_addr",  32'(imem_addr), 0);
        chk("F_ir",    if_ir, 0);
        #2 rst_n = 1'b1;
        tick(1);
        chk("F_stale_ignored", 32'(if_valid), 0);
        chk("F_addr_next",     32'(imem_addr), 1);
        tick(1);
        chk("F_valid_restart", 32'(if_valid), 1);
        chk("F_ir_restart",    if_ir, 100);
        chk("F_npc_restart",   if_npc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
